// File: rtl/agg_beat_sched.sv
// agg_beat_sched -- round-robin scheduler of two aggregate-word requesters onto
// one narrow beat bus. The granted word is captured, zero-extended to
// NBEATS*BEAT_W bits and shifted out LSB-first, one BEAT_W beat per accepted
// handshake, with out_last on the final beat.
//
// Ports:
//   clock, reset_n          clock (rising edge), async active-low reset
//   reqN_valid/ready/data   requester N word handshake (ready is combinational)
//   out_valid/ready/data    beat handshake toward the sink
//   out_last                final beat of the frame
//   out_src                 requester index of the frame being sent
//   busy                    frame in flight
//   out_par                 XOR of out_data (only with AGG_BEAT_SCHED_PARITY_EN)
//
// Optional feature macro: AGG_BEAT_SCHED_PARITY_EN
module agg_beat_sched #(
  parameter int AGG_W  = 63,
  parameter int BEAT_W = 16
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [AGG_W-1:0]  req0_data,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [AGG_W-1:0]  req1_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [BEAT_W-1:0] out_data,
  output logic              out_last,
  output logic              out_src,
`ifdef AGG_BEAT_SCHED_PARITY_EN
  output logic              out_par,
`endif
  output logic              busy
);

  localparam int NBEATS = (AGG_W + BEAT_W - 1) / BEAT_W;
  localparam int CNT_W  = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam int SHW    = NBEATS * BEAT_W;

  typedef enum logic {IDLE, SEND} state_e;

  state_e           state_q, state_d;
  logic [SHW-1:0]   shreg_q, shreg_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             src_q, src_d;
  logic             rr_q, rr_d;
  logic             gnt0, gnt1, last;

  // rr names the requester favoured when both are valid.
  assign gnt0 = req0_valid && (!req1_valid || !rr_q);
  assign gnt1 = req1_valid && (!req0_valid ||  rr_q);
  assign last = (cnt_q == CNT_W'(NBEATS - 1));

  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    cnt_d      = cnt_q;
    src_d      = src_q;
    rr_d       = rr_q;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    out_valid  = 1'b0;
    out_data   = '0;
    out_last   = 1'b0;
    out_src    = 1'b0;
    busy       = 1'b0;
    case (state_q)
      IDLE: begin
        // State already reads IDLE during reset; gate so no word is taken then.
        req0_ready = gnt0 && reset_n;
        req1_ready = gnt1 && reset_n;
        if (gnt0 || gnt1) begin
          shreg_d = gnt1 ? SHW'(req1_data) : SHW'(req0_data);
          cnt_d   = '0;
          src_d   = gnt1;
          rr_d    = ~gnt1;
          state_d = SEND;
        end
      end
      SEND: begin
        out_valid = 1'b1;
        out_data  = shreg_q[BEAT_W-1:0];
        out_last  = last;
        out_src   = src_q;
        busy      = 1'b1;
        if (out_ready) begin
          shreg_d = shreg_q >> BEAT_W;
          if (last) state_d = IDLE;
          else      cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      src_q   <= 1'b0;
      rr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      src_q   <= src_d;
      rr_q    <= rr_d;
    end
  end

`ifdef AGG_BEAT_SCHED_PARITY_EN
  // out_data is forced to 0 outside SEND, so parity is 0 there as well.
  assign out_par = ^out_data;
`endif

endmodule
